muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers, placed beside ALU32Bit in EX.
//   Accepts an operation from the Controller/ALUControl decode, iterates one bit per cycle and writes HI/LO.
//   Drives a Stall signal that freezes upstream stages while a result is pending.
//   Services MTHI/MTLO writes; MFHI/MFLO read the Hi/Lo outputs directly.
// PARAMETERS
//   DATA_W  32  operand/result width; iteration count = DATA_W
// PORTS
//   Clk        in   1       clock, rising-edge
//   Rst        in   1       asynchronous, active-low reset
//   Start      in   1       launch operation Op on A,B (sampled in IDLE only)
//   Op         in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A          in   DATA_W  multiplicand / dividend (rs)
//   B          in   DATA_W  multiplier / divisor (rt)
//   Abort      in   1       synchronous cancel (branch flush / exception)
//   HiWrite    in   1       MTHI: Hi <= WData
//   LoWrite    in   1       MTLO: Lo <= WData
//   WData      in   DATA_W  MTHI/MTLO data
//   Busy       out  1       operation in flight
//   Stall      out  1       Busy | Start; combinational
//   Done       out  1       one-cycle pulse: Hi/Lo hold the new result
//   DivByZero  out  1       pulses with Done when a DIV/DIVU had B==0
//   Hi         out  DATA_W  HI register (product high / remainder)
//   Lo         out  DATA_W  LO register (product low / quotient)
// BEHAVIOUR
//   Reset (Rst=0, any time, incl. mid-run): state IDLE, Hi=Lo=0, Busy=Done=DivByZero=0, counter=0.
//   States: IDLE -> RUN -> FIX -> IDLE.
//   IDLE + Start (edge E0): latch |A|, |B|, result sign(s), Op; counter=0; -> RUN.
//   Signed ops use magnitudes. Unsigned ops use raw operands. Magnitude of 0x80000000 is 0x80000000 (32-bit unsigned).
//   RUN (edges E1..E32): one shift-add (mul) or restoring shift-subtract (div) step per edge.
//   RUN exits to FIX when counter==DATA_W-1.
//   FIX (edge E33): apply sign correction and write Hi/Lo. Done=1 for the following cycle only; -> IDLE.
//   Latency: Done high exactly DATA_W+1 cycles after the Start edge.
//   Busy=1 from E0 until E33. Busy is 0 in the Done cycle, so a new Start may be issued in that cycle.
//   MULT: 64-bit product negated if signs differ; Hi=[63:32], Lo=[31:0].
//   DIV: quotient negated if signs differ; remainder takes dividend sign.
//   DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0 (no trap).
//   B==0 on DIV/DIVU: skip RUN; E0 -> FIX.
//     At E1: Hi=A, Lo=all-ones, Done=1, DivByZero=1.
//   Start while Busy: ignored; no error.
//   Abort: any state -> IDLE at next edge; Hi/Lo unchanged; no Done.
//     Abort+Start in IDLE: Abort wins and nothing launches.
//     Abort in the FIX cycle: the write is suppressed.
//   HiWrite/LoWrite: honoured only when Busy=0 and not Start; otherwise dropped.
//     A result write in FIX has priority over any MTHI/MTLO in the same cycle.
//   Stall equals Busy|Start and is not registered.
// STRUCTURE
//   Shared header muldiv_defs.vh:
//     Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
//     State encodings (S_IDLE, S_RUN, S_FIX).
//     Funct codes 0x18/0x19/0x1A/0x1B and 0x11/0x13 for decode in ALUControl.
//   Sub-module muldiv_iter_step (combinational):
//     Inputs: Op class, partial (2*DATA_W), operand.
//     Output: next partial for one iteration.
//   Top level holds the FSM, counter, sign logic and Hi/Lo.
// TESTING
//   MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; Done 33 cycles after Start edge; Busy low with Done.
//   MULT -3*5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
//   MULT 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
//   DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
//   DIVU 7/2 -> Lo=3, Hi=1.
//   DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
//   DIVU 5/0 -> Done+DivByZero one cycle after Start, Hi=5, Lo=0xFFFFFFFF.
//   Start during RUN ignored; Abort at iteration 10 -> IDLE, Hi/Lo keep prior values, no Done.
//   MTLO of 0x1234 while Busy is dropped.
//   Rst low mid-run -> Busy=0 and Hi=Lo=0 without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
//   op_e     : operation encodings presented on Op
//   state_e  : sequencer states (IDLE -> RUN -> FIX -> IDLE)
//   FUNCT_*  : R-type funct codes that ALUControl decodes onto this unit
package muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_sequencer_iter_step.sv
// One iteration of the unsigned multiply / divide datapath (combinational).
//   is_div      : 1 = restoring shift-subtract step, 0 = shift-add step
//   partial_in  : {upper, lower} working register, 2*DATA_W bits
//   operand     : multiplier magnitude (mul) or divisor magnitude (div)
//   partial_out : working register after this iteration
// Multiply: lower starts as the multiplicand; after DATA_W steps the pair
// holds the 64-bit product. Divide: lower starts as the dividend; after
// DATA_W steps upper is the remainder and lower the quotient.
module muldiv_sequencer_iter_step #(
    parameter int DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   partial_in,
    input  logic [DATA_W-1:0]     operand,
    output logic [2*DATA_W-1:0]   partial_out
);

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_trial;
    logic [DATA_W:0]   div_diff;
    logic [DATA_W-1:0] mul_addend;

    always_comb begin
        mul_addend = partial_in[0] ? operand : '0;
        // Carry out of the add is kept and shifted back into the top bit.
        mul_sum    = {1'b0, partial_in[2*DATA_W-1:DATA_W]} + {1'b0, mul_addend};
        // Remainder shifted left by one with the next dividend bit brought in;
        // one extra bit so the trial subtraction exposes its borrow in bit DATA_W.
        div_trial  = partial_in[2*DATA_W-1:DATA_W-1];
        div_diff   = div_trial - {1'b0, operand};

        partial_out = '0;
        if (is_div) begin
            if (!div_diff[DATA_W]) begin
                partial_out = {div_diff[DATA_W-1:0], partial_in[DATA_W-2:0], 1'b1};
            end else begin
                partial_out = {partial_in[2*DATA_W-2:0], 1'b0};
            end
        end else begin
            partial_out = {mul_sum, partial_in[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Ports:
//   Clk, Rst       : rising-edge clock, asynchronous active-low reset
//   Start, Op, A, B: launch an operation (sampled only when idle)
//   Abort          : cancel whatever is in flight; Hi/Lo left untouched
//   HiWrite/LoWrite/WData : MTHI/MTLO, honoured only when idle and not starting
//   Busy, Stall    : operation in flight; Stall = Busy | Start (combinational)
//   Done, DivByZero: one-cycle pulse when Hi/Lo carry a new result
//   Hi, Lo         : HI/LO registers
// Operands are reduced to magnitudes at launch, the unsigned core iterates
// one bit per clock, and the sign is restored in FIX as the result is written.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Abort,
    input  logic              HiWrite,
    input  logic              LoWrite,
    input  logic [DATA_W-1:0] WData,
    output logic              Busy,
    output logic              Stall,
    output logic              Done,
    output logic              DivByZero,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic                is_div_reg;
    logic                neg_q_reg;      // product / quotient must be negated
    logic                neg_r_reg;      // remainder must be negated
    logic                dbz_pend_reg;   // divide by zero: RUN skipped
    logic [DATA_W-1:0]   operand_reg;
    logic [2*DATA_W-1:0] partial_reg;
    logic [2*DATA_W-1:0] partial_step;
    logic [DATA_W-1:0]   hi_reg, lo_reg;
    logic                done_reg, dbz_reg;

    op_e                 op_in;
    logic                op_is_div, op_signed, launch, launch_dbz;
    logic [DATA_W-1:0]   a_mag, b_mag;

    logic [2*DATA_W-1:0] prod_fixed;
    logic [DATA_W-1:0]   quot_fixed, rem_fixed, fix_hi, fix_lo;

    assign op_in = op_e'(Op);

    always_comb begin
        op_is_div  = (op_in == OP_DIV) || (op_in == OP_DIVU);
        op_signed  = (op_in == OP_MULT) || (op_in == OP_DIV);
        // The most negative value maps onto itself, which read as unsigned is
        // exactly its magnitude, so no special case is needed.
        a_mag      = (op_signed && A[DATA_W-1]) ? -A : A;
        b_mag      = (op_signed && B[DATA_W-1]) ? -B : B;
        launch     = (state_reg == S_IDLE) && Start && !Abort;
        launch_dbz = op_is_div && (B == '0);
    end

    muldiv_sequencer_iter_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .is_div      (is_div_reg),
        .partial_in  (partial_reg),
        .operand     (operand_reg),
        .partial_out (partial_step)
    );

    // Sign restoration and result selection for the FIX write.
    always_comb begin
        prod_fixed = neg_q_reg ? -partial_reg : partial_reg;
        quot_fixed = neg_q_reg ? -(partial_reg[DATA_W-1:0]) : partial_reg[DATA_W-1:0];
        rem_fixed  = neg_r_reg ? -(partial_reg[2*DATA_W-1:DATA_W])
                               : partial_reg[2*DATA_W-1:DATA_W];
        if (dbz_pend_reg) begin
            // Raw dividend was parked in the low half at launch.
            fix_hi = partial_reg[DATA_W-1:0];
            fix_lo = '1;
        end else if (is_div_reg) begin
            fix_hi = rem_fixed;
            fix_lo = quot_fixed;
        end else begin
            fix_hi = prod_fixed[2*DATA_W-1:DATA_W];
            fix_lo = prod_fixed[DATA_W-1:0];
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; Abort beats everything, including a launch.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (launch) begin
                    state_next = launch_dbz ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (Abort) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath, counter and HI/LO
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_reg      <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dbz_pend_reg <= 1'b0;
            operand_reg  <= '0;
            partial_reg  <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (launch) begin
                        cnt_reg      <= '0;
                        is_div_reg   <= op_is_div;
                        neg_q_reg    <= op_signed && (A[DATA_W-1] ^ B[DATA_W-1]);
                        neg_r_reg    <= op_signed && A[DATA_W-1];
                        dbz_pend_reg <= launch_dbz;
                        operand_reg  <= b_mag;
                        partial_reg  <= {{DATA_W{1'b0}}, (launch_dbz ? A : a_mag)};
                    end else if (!Start) begin
                        if (HiWrite) begin
                            hi_reg <= WData;
                        end
                        if (LoWrite) begin
                            lo_reg <= WData;
                        end
                    end
                end
                S_RUN: begin
                    if (!Abort) begin
                        partial_reg <= partial_step;
                        cnt_reg     <= cnt_reg + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (!Abort) begin
                        hi_reg   <= fix_hi;
                        lo_reg   <= fix_lo;
                        done_reg <= 1'b1;
                        dbz_reg  <= dbz_pend_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy      = (state_reg != S_IDLE);
    assign Stall     = Busy | Start;
    assign Done      = done_reg;
    assign DivByZero = dbz_reg;
    assign Hi        = hi_reg;
    assign Lo        = lo_reg;

endmodule
